// File: rtl/decode_pkg.sv
// Opcode/funct constants, ALU/branch op encodings and shared types for the decode stage.
// Latency/backpressure: n/a (definitions only).
package decode_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [4:0] RT_BLTZ = 5'd0;
  localparam logic [4:0] RT_BGEZ = 5'd1;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_NOR  = 5'd5;
  localparam logic [4:0] ALU_SLT  = 5'd6;
  localparam logic [4:0] ALU_SLTU = 5'd7;
  localparam logic [4:0] ALU_SLL  = 5'd8;
  localparam logic [4:0] ALU_SRL  = 5'd9;
  localparam logic [4:0] ALU_SRA  = 5'd10;
  localparam logic [4:0] ALU_LUI  = 5'd11;
  localparam logic [4:0] ALU_LINK = 5'd12;

  localparam logic [3:0] BR_NONE = 4'd0;
  localparam logic [3:0] BR_BEQ  = 4'd1;
  localparam logic [3:0] BR_BNE  = 4'd2;
  localparam logic [3:0] BR_BLEZ = 4'd3;
  localparam logic [3:0] BR_BGTZ = 4'd4;
  localparam logic [3:0] BR_BLTZ = 4'd5;
  localparam logic [3:0] BR_BGEZ = 4'd6;
  localparam logic [3:0] BR_J    = 4'd7;
  localparam logic [3:0] BR_JR   = 4'd8;

  typedef struct packed {
    logic       reg_we;
    logic       dmem_we;
    logic       s_wrd;
    logic       s_a0;
    logic       s_a;
    logic       s_b;
    logic       s_byte;
    logic       s_imme;
    logic       sign;
    logic       s_load;
    logic [4:0] alu_op;
    logic [3:0] br_op;
  } ctrl_t;

  typedef struct packed {
    logic [4:0] wa;
    logic       we;
    logic       ld;
  } hz_rec_t;

  // r0 is hardwired, so a pending write to it must never be forwarded.
  function automatic logic rec_match(hz_rec_t r, logic [4:0] ra);
    return r.we && (r.wa == ra) && (ra != 5'd0);
  endfunction

endpackage

// File: rtl/decode_table.sv
// Opcode/funct/rt to control-word lookup; unknown encodings yield an all-zero bubble.
// Latency: combinational. Backpressure: none.
module decode_table
  import decode_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (op)
      OP_RTYPE: begin
        ctrl.reg_we = 1'b1;
        case (funct)
          FN_ADDU: ctrl.alu_op = ALU_ADD;
          FN_SUBU: ctrl.alu_op = ALU_SUB;
          FN_AND:  ctrl.alu_op = ALU_AND;
          FN_OR:   ctrl.alu_op = ALU_OR;
          FN_XOR:  ctrl.alu_op = ALU_XOR;
          FN_NOR:  ctrl.alu_op = ALU_NOR;
          FN_SLT:  ctrl.alu_op = ALU_SLT;
          FN_SLTU: ctrl.alu_op = ALU_SLTU;
          FN_SLL: begin ctrl.alu_op = ALU_SLL; ctrl.s_imme = 1'b1; ctrl.s_a0 = 1'b1; end
          FN_SRL: begin ctrl.alu_op = ALU_SRL; ctrl.s_imme = 1'b1; ctrl.s_a0 = 1'b1; end
          FN_SRA: begin ctrl.alu_op = ALU_SRA; ctrl.s_imme = 1'b1; ctrl.s_a0 = 1'b1; end
          FN_SLLV: ctrl.alu_op = ALU_SLL;
          FN_SRLV: ctrl.alu_op = ALU_SRL;
          FN_SRAV: ctrl.alu_op = ALU_SRA;
          FN_JR: begin ctrl.reg_we = 1'b0; ctrl.br_op = BR_JR; end
          FN_JALR: begin ctrl.br_op = BR_JR; ctrl.s_a = 1'b1; ctrl.alu_op = ALU_LINK; end
          default: ctrl = '0;
        endcase
      end
      OP_REGIMM: begin
        ctrl.sign = 1'b1;
        case (rt)
          RT_BLTZ: ctrl.br_op = BR_BLTZ;
          RT_BGEZ: ctrl.br_op = BR_BGEZ;
          default: ctrl = '0;
        endcase
      end
      OP_J:    ctrl.br_op = BR_J;
      OP_JAL:  begin ctrl.br_op = BR_J; ctrl.reg_we = 1'b1; ctrl.s_a = 1'b1; ctrl.alu_op = ALU_LINK; end
      OP_BEQ:  begin ctrl.br_op = BR_BEQ;  ctrl.sign = 1'b1; end
      OP_BNE:  begin ctrl.br_op = BR_BNE;  ctrl.sign = 1'b1; end
      OP_BLEZ: begin ctrl.br_op = BR_BLEZ; ctrl.sign = 1'b1; end
      OP_BGTZ: begin ctrl.br_op = BR_BGTZ; ctrl.sign = 1'b1; end
      OP_ADDIU: begin ctrl.reg_we = 1'b1; ctrl.s_b = 1'b1; ctrl.sign = 1'b1; ctrl.alu_op = ALU_ADD;  end
      OP_SLTI:  begin ctrl.reg_we = 1'b1; ctrl.s_b = 1'b1; ctrl.sign = 1'b1; ctrl.alu_op = ALU_SLT;  end
      OP_SLTIU: begin ctrl.reg_we = 1'b1; ctrl.s_b = 1'b1; ctrl.sign = 1'b1; ctrl.alu_op = ALU_SLTU; end
      OP_ANDI:  begin ctrl.reg_we = 1'b1; ctrl.s_b = 1'b1; ctrl.alu_op = ALU_AND; end
      OP_ORI:   begin ctrl.reg_we = 1'b1; ctrl.s_b = 1'b1; ctrl.alu_op = ALU_OR;  end
      OP_XORI:  begin ctrl.reg_we = 1'b1; ctrl.s_b = 1'b1; ctrl.alu_op = ALU_XOR; end
      OP_LUI:   begin ctrl.reg_we = 1'b1; ctrl.s_b = 1'b1; ctrl.alu_op = ALU_LUI; end
      OP_LW, OP_LB, OP_LBU: begin
        ctrl.reg_we = 1'b1;
        ctrl.s_b    = 1'b1;
        ctrl.sign   = 1'b1;
        ctrl.s_wrd  = 1'b1;
        ctrl.s_load = 1'b1;
        ctrl.s_byte = (op != OP_LW);
      end
      OP_SW, OP_SB: begin
        ctrl.dmem_we = 1'b1;
        ctrl.s_b     = 1'b1;
        ctrl.sign    = 1'b1;
        ctrl.s_byte  = (op == OP_SB);
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/decode_ctrl_hazard.sv
// Decode stage: controls, immediate, destination, E/M/W forwarding and load-use stall.
// Latency: combinational outputs; hazard records advance each clk. Backpressure: pause holds fetch/decode one cycle.
module decode_ctrl_hazard
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  input  logic [31:0] aluOutE,
  input  logic [31:0] dMemRDataM,
  input  logic [31:0] rstW,
  output logic        regWe,
  output logic        dMemWe,
  output logic        sWRD,
  output logic        sA0,
  output logic        sA,
  output logic        sB,
  output logic        sByte,
  output logic [4:0]  aluOP,
  output logic [3:0]  brOP,
  output logic [4:0]  WRA,
  output logic [31:0] num,
  output logic [31:0] fwd1,
  output logic [31:0] fwd2,
  output logic        pause
);

  ctrl_t      ctrl;
  hz_rec_t    rec_e, rec_m, rec_w;
  logic [4:0] rs, rt;
  logic [15:0] imm_src;

  assign rs = inst[25:21];
  assign rt = inst[20:16];

  decode_table u_table (
    .op    (inst[31:26]),
    .funct (inst[5:0]),
    .rt    (rt),
    .ctrl  (ctrl)
  );

  assign regWe  = ctrl.reg_we;
  assign dMemWe = ctrl.dmem_we;
  assign sWRD   = ctrl.s_wrd;
  assign sA0    = ctrl.s_a0;
  assign sA     = ctrl.s_a;
  assign sB     = ctrl.s_b;
  assign sByte  = ctrl.s_byte;
  assign aluOP  = ctrl.alu_op;
  assign brOP   = ctrl.br_op;

  assign imm_src = ctrl.s_imme ? {11'b0, inst[10:6]} : inst[15:0];
  assign num     = ctrl.sign ? {{16{imm_src[15]}}, imm_src} : {16'b0, imm_src};

  always_comb begin
    WRA = rt;
    if (inst[31:26] == OP_JAL)        WRA = 5'd31;
    else if (inst[31:26] == OP_RTYPE) WRA = inst[15:11];
  end

  // Operand use is not checked: a false stall costs a cycle, a missed one corrupts data.
  assign pause = rec_e.ld && (rec_match(rec_e, rs) || rec_match(rec_e, rt));

  always_comb begin
    fwd1 = rd1;
    if (!pause) begin
      if (rec_match(rec_e, rs))      fwd1 = aluOutE;
      else if (rec_match(rec_m, rs)) fwd1 = dMemRDataM;
      else if (rec_match(rec_w, rs)) fwd1 = rstW;
    end
  end

  always_comb begin
    fwd2 = rd2;
    if (!pause) begin
      if (rec_match(rec_e, rt))      fwd2 = aluOutE;
      else if (rec_match(rec_m, rt)) fwd2 = dMemRDataM;
      else if (rec_match(rec_w, rt)) fwd2 = rstW;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rec_e <= '0;
      rec_m <= '0;
      rec_w <= '0;
    end else begin
      rec_w <= rec_m;
      rec_m <= rec_e;
      rec_e <= pause ? hz_rec_t'('0) : hz_rec_t'{wa: WRA, we: ctrl.reg_we, ld: ctrl.s_load};
    end
  end

endmodule

// File: tb/tb_decode_ctrl_hazard.sv
// Directed bench: decode vector table plus hand-written forwarding/stall sequences.
module tb_decode_ctrl_hazard;

  logic        clk, rst;
  logic [31:0] inst, rd1, rd2, aluOutE, dMemRDataM, rstW;
  logic        regWe, dMemWe, sWRD, sA0, sA, sB, sByte, pause;
  logic [4:0]  aluOP, WRA;
  logic [3:0]  brOP;
  logic [31:0] num, fwd1, fwd2;

  int n_tests = 0;
  int n_fail  = 0;

  decode_ctrl_hazard dut (
    .clk(clk), .rst(rst), .inst(inst), .rd1(rd1), .rd2(rd2),
    .aluOutE(aluOutE), .dMemRDataM(dMemRDataM), .rstW(rstW),
    .regWe(regWe), .dMemWe(dMemWe), .sWRD(sWRD), .sA0(sA0), .sA(sA),
    .sB(sB), .sByte(sByte), .aluOP(aluOP), .brOP(brOP), .WRA(WRA),
    .num(num), .fwd1(fwd1), .fwd2(fwd2), .pause(pause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl = {regWe, dMemWe, sWRD, sA0, sA, sB, sByte}
  typedef struct {
    logic [31:0] inst;
    logic [6:0]  ctl;
    logic [4:0]  alu;
    logic [3:0]  br;
    logic [4:0]  wra;
    logic [31:0] num;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{32'h2402FFFF, 7'b1000010, 5'd0,  4'd0, 5'd2,  32'hFFFFFFFF}; // addiu $2,$0,-1
    tbl[1]  = '{32'h3403FFFF, 7'b1000010, 5'd3,  4'd0, 5'd3,  32'h0000FFFF}; // ori $3,$0,0xffff
    tbl[2]  = '{32'h00041940, 7'b1001000, 5'd8,  4'd0, 5'd3,  32'h00000005}; // sll $3,$4,5
    tbl[3]  = '{32'h0C000100, 7'b1000100, 5'd12, 4'd7, 5'd31, 32'h00000100}; // jal
    tbl[4]  = '{32'hFC43FFFF, 7'b0000000, 5'd0,  4'd0, 5'd3,  32'h0000FFFF}; // opcode 0x3F
    tbl[5]  = '{32'h8C27FFFC, 7'b1010010, 5'd0,  4'd0, 5'd7,  32'hFFFFFFFC}; // lw $7,-4($1)
    tbl[6]  = '{32'hA0450003, 7'b0100011, 5'd0,  4'd0, 5'd5,  32'h00000003}; // sb $5,3($2)
    tbl[7]  = '{32'h1022FFFF, 7'b0000000, 5'd0,  4'd1, 5'd2,  32'hFFFFFFFF}; // beq $1,$2,-1
    tbl[8]  = '{32'h04610008, 7'b0000000, 5'd0,  4'd6, 5'd1,  32'h00000008}; // bgez $3,8
    tbl[9]  = '{32'h0080F809, 7'b1000100, 5'd12, 4'd8, 5'd31, 32'h0000F809}; // jalr $31,$4
    tbl[10] = '{32'h03E00008, 7'b0000000, 5'd0,  4'd8, 5'd0,  32'h00000008}; // jr $31
    tbl[11] = '{32'h3C098000, 7'b1000010, 5'd11, 4'd0, 5'd9,  32'h00008000}; // lui $9,0x8000
    tbl[12] = '{32'h000217C3, 7'b1001000, 5'd10, 4'd0, 5'd2,  32'h0000001F}; // sra $2,$2,31
    tbl[13] = '{32'h00A6202A, 7'b1000000, 5'd6,  4'd0, 5'd4,  32'h0000202A}; // slt $4,$5,$6
    tbl[14] = '{32'h28A4FFFE, 7'b1000010, 5'd6,  4'd0, 5'd4,  32'hFFFFFFFE}; // slti $4,$5,-2
    tbl[15] = '{32'h00000000, 7'b1001000, 5'd8,  4'd0, 5'd0,  32'h00000000}; // flush = sll $0

    rst = 1'b1; inst = 32'h0;
    rd1 = 32'h11; rd2 = 32'h22;
    aluOutE = 32'h1234; dMemRDataM = 32'hBBBB; rstW = 32'hCCCC;
    step(); step();
    inst = 32'h00A53021;
    #1;
    check("reset_pause", {63'b0, pause}, 64'd0);
    check("reset_fwd1", {32'b0, fwd1}, 64'h11);
    rst = 1'b0;
    step();

    // E, then M, then W forwarding of $5
    inst = 32'h00222821; step();
    inst = 32'h00A53021; #1;
    check("fwdE_fwd1", {32'b0, fwd1}, 64'h1234);
    check("fwdE_fwd2", {32'b0, fwd2}, 64'h1234);
    check("fwdE_pause", {63'b0, pause}, 64'd0);
    step();
    check("fwdM_fwd1", {32'b0, fwd1}, 64'hBBBB);
    step();
    check("fwdW_fwd2", {32'b0, fwd2}, 64'hCCCC);

    // load-use: one stall cycle, then forward from M
    dMemRDataM = 32'hCAFE;
    inst = 32'h8C270000; step();
    inst = 32'h00E04021; #1;
    check("lu_pause", {63'b0, pause}, 64'd1);
    check("lu_stall_fwd1", {32'b0, fwd1}, 64'h11);
    step();
    check("lu_after_pause", {63'b0, pause}, 64'd0);
    check("lu_after_fwd1", {32'b0, fwd1}, 64'hCAFE);
    check("lu_after_fwd2", {32'b0, fwd2}, 64'h22);

    // write to $0 in E must not forward
    aluOutE = 32'h5555;
    inst = 32'h24200005; step();
    inst = 32'h00004821; #1;
    check("r0_fwd1", {32'b0, fwd1}, 64'h11);
    check("r0_fwd2", {32'b0, fwd2}, 64'h22);

    // E over M, then M over older W, all on $10
    aluOutE = 32'h1234; dMemRDataM = 32'hBBBB; rstW = 32'hCCCC;
    inst = 32'h00225021; step();
    inst = 32'h00225021; step();
    inst = 32'h01405821; #1;
    check("prio_E_over_M", {32'b0, fwd1}, 64'h1234);
    step();
    check("prio_M_over_W", {32'b0, fwd1}, 64'hBBBB);

    // reset during a load-use stall drops it
    inst = 32'h8C270000; step();
    inst = 32'h00E04021; #1;
    check("rst_stall_pause", {63'b0, pause}, 64'd1);
    rst = 1'b1; step(); rst = 1'b0; #1;
    check("rst_mid_pause", {63'b0, pause}, 64'd0);
    check("rst_mid_fwd1", {32'b0, fwd1}, 64'h11);

    for (int i = 0; i < NV; i++) begin
      inst = tbl[i].inst;
      #1;
      check($sformatf("dec[%0d]", i),
            {11'b0, regWe, dMemWe, sWRD, sA0, sA, sB, sByte, aluOP, brOP, WRA, num},
            {11'b0, tbl[i].ctl, tbl[i].alu, tbl[i].br, tbl[i].wra, tbl[i].num});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
